// File: rtl/snn_noc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : snn_noc_pkg
//  Description : Shared constants, FSM state type and helpers for the
//                spiking-neuron address transmitter.
//  Revision    : 1.0 - initial release
// ============================================================================
package snn_noc_pkg;

    // Default widths used by the transmitter and its interface.
    localparam int c_ADDR_W      = 12;
    localparam int c_NUM_NEURONS = 10;

    // Transmitter FSM states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width of a neuron index. A minimum of one bit keeps single-neuron
    // builds legal.
    function automatic int f_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : snn_noc_pkg
`default_nettype wire

// File: rtl/spike_address_tx_if.sv
`default_nettype none
// ============================================================================
//  Module      : spike_address_tx_if
//  Description : Fire-vector input and address handshake bundle of the
//                spike address transmitter. The slave modport is the
//                transmitter side, the master modport is the driving side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface spike_address_tx_if
    import snn_noc_pkg::*;
#(
    parameter int NUM_NEURONS = c_NUM_NEURONS,
    parameter int ADDR_W      = c_ADDR_W
) ();

    logic [ADDR_W-1:0]      base_address;
    logic [NUM_NEURONS-1:0] fire_vec;
    logic                   fire_valid;
    logic                   addr_ready;
    logic [ADDR_W-1:0]      source_address;
    logic                   addr_valid;
    logic                   busy;
    logic                   done;
    logic [7:0]             ovf_count;

    modport master (
        output base_address,
        output fire_vec,
        output fire_valid,
        output addr_ready,
        input  source_address,
        input  addr_valid,
        input  busy,
        input  done,
        input  ovf_count
    );

    modport slave (
        input  base_address,
        input  fire_vec,
        input  fire_valid,
        input  addr_ready,
        output source_address,
        output addr_valid,
        output busy,
        output done,
        output ovf_count
    );

endinterface : spike_address_tx_if
`default_nettype wire

// File: rtl/spike_prio_enc.sv
`default_nettype none
// ============================================================================
//  Module      : spike_prio_enc
//  Description : Combinational lowest-set-bit priority encoder. index is the
//                position of the lowest set bit of mask; any flags a
//                non-zero mask (index is 0 when any is 0).
//  Revision    : 1.0 - initial release
// ============================================================================
module spike_prio_enc #(
    parameter int WIDTH = 10,
    parameter int IDX_W = 4
) (
    input  wire logic [WIDTH-1:0] mask,
    output logic      [IDX_W-1:0] index,
    output logic                  any
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        index = '0;
        any   = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (mask[i]) begin
                index = IDX_W'(i);
                any   = 1'b1;
            end
        end
    end

endmodule : spike_prio_enc
`default_nettype wire

// File: rtl/spike_address_tx.sv
`default_nettype none
// ============================================================================
//  Module      : spike_address_tx
//  Description : Converts a per-timestep neuron fire vector into a stream of
//                source addresses (base_address + neuron index), lowest
//                index first, over a valid/ready handshake. A done pulse
//                closes every accepted timestep, including empty ones.
//                Strobes arriving while busy are dropped.
//  Options     : SPIKE_ADDRESS_TX_OVF_COUNT_EN - when defined, a saturating
//                8-bit counter of dropped strobes drives ovf_count;
//                otherwise ovf_count is tied to zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module spike_address_tx
    import snn_noc_pkg::*;
#(
    parameter int NUM_NEURONS = c_NUM_NEURONS,
    parameter int ADDR_W      = c_ADDR_W
) (
    input  wire logic          CLK,
    input  wire logic          RST,
    spike_address_tx_if.slave  bus
);

    localparam int                     c_IDX_W = f_idx_w(NUM_NEURONS);
    localparam logic [NUM_NEURONS-1:0] c_ONE   = NUM_NEURONS'(1);

    state_t                 r_state;
    logic [NUM_NEURONS-1:0] r_pending;
    logic [ADDR_W-1:0]      r_base;
    logic [ADDR_W-1:0]      r_source_address;
    logic                   r_addr_valid;
    logic                   r_busy;
    logic                   r_done;

    logic [NUM_NEURONS-1:0] w_pending_next;
    logic [NUM_NEURONS-1:0] w_enc_mask;
    logic [c_IDX_W-1:0]     w_idx;
    logic                   w_any;
    logic                   w_xfer;

    assign w_xfer = r_addr_valid & bus.addr_ready;

    // The encoder looks at the incoming vector while idle (so the first
    // address is ready the cycle after the latch) and at the pending mask
    // minus its lowest bit while sending (the address that follows a
    // completed transfer). Clearing the lowest set bit is x & (x - 1).
    always_comb begin
        w_pending_next = r_pending & (r_pending - c_ONE);
        w_enc_mask     = (r_state == IDLE) ? bus.fire_vec : w_pending_next;
    end

    spike_prio_enc #(
        .WIDTH (NUM_NEURONS),
        .IDX_W (c_IDX_W)
    ) u_prio_enc (
        .mask  (w_enc_mask),
        .index (w_idx),
        .any   (w_any)
    );

    // Transmit FSM with registered address, valid, busy and done outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state          <= IDLE;
            r_pending        <= '0;
            r_base           <= '0;
            r_source_address <= '0;
            r_addr_valid     <= 1'b0;
            r_busy           <= 1'b0;
            r_done           <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.fire_valid) begin
                        r_pending <= bus.fire_vec;
                        r_base    <= bus.base_address;
                        r_busy    <= 1'b1;
                        if (w_any) begin
                            r_state          <= SEND;
                            r_source_address <= bus.base_address + ADDR_W'(w_idx);
                            r_addr_valid     <= 1'b1;
                        end else begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                SEND: begin
                    if (w_xfer) begin
                        r_pending <= w_pending_next;
                        if (w_any) begin
                            r_source_address <= r_base + ADDR_W'(w_idx);
                        end else begin
                            r_addr_valid <= 1'b0;
                            r_state      <= DONE;
                            r_done       <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state      <= IDLE;
                    r_pending    <= '0;
                    r_addr_valid <= 1'b0;
                    r_done       <= 1'b0;
                    r_busy       <= 1'b0;
                end
            endcase
        end
    end

    assign bus.source_address = r_source_address;
    assign bus.addr_valid     = r_addr_valid;
    assign bus.busy           = r_busy;
    assign bus.done           = r_done;

`ifdef SPIKE_ADDRESS_TX_OVF_COUNT_EN
    logic       w_reject;
    logic [7:0] r_ovf_count;

    // Strobes are only accepted in IDLE; any other state drops them.
    assign w_reject = bus.fire_valid & (r_state != IDLE);

    // Saturating count of dropped strobes.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_ovf_count <= 8'h00;
        end else if (w_reject && (r_ovf_count != 8'hFF)) begin
            r_ovf_count <= r_ovf_count + 8'd1;
        end
    end

    assign bus.ovf_count = r_ovf_count;
`else
    assign bus.ovf_count = 8'h00;
`endif

endmodule : spike_address_tx
`default_nettype wire

// File: tb/tb_spike_address_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spike_address_tx
//  Description : Scoreboard bench for spike_address_tx. Each accepted fire
//                vector is expanded into its expected address list plus an
//                end-of-timestep marker; a negedge monitor consumes the
//                queue as the DUT hands addresses over.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spike_address_tx;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    always #5 CLK = ~CLK;

    spike_address_tx_if #(.NUM_NEURONS(10), .ADDR_W(12)) bus ();

    spike_address_tx #(
        .NUM_NEURONS (10),
        .ADDR_W      (12)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    typedef struct packed {
        logic        is_done;
        logic [11:0] addr;
    } exp_t;

    exp_t q_exp[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   model_ovf = 0;
    bit   mon_en = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int exp_ovf();
`ifdef SPIKE_ADDRESS_TX_OVF_COUNT_EN
        return model_ovf;
`else
        return 0;
`endif
    endfunction

    function automatic void note_reject();
        if (model_ovf < 255) model_ovf++;
    endfunction

    // Reference: every set bit, ascending, gives (base + index) mod 4096,
    // then the timestep closes with a done marker.
    function automatic void push_expect(input logic [11:0] base, input logic [9:0] vec);
        exp_t e;
        for (int i = 0; i < 10; i++) begin
            if (vec[i]) begin
                e.is_done = 1'b0;
                e.addr    = 12'((int'(base) + i) % 4096);
                q_exp.push_back(e);
            end
        end
        e.is_done = 1'b1;
        e.addr    = 12'h000;
        q_exp.push_back(e);
    endfunction

    // Monitor: compares the DUT against the head of the expectation queue.
    logic        prev_stall = 1'b0;
    logic [11:0] prev_addr  = '0;
    always @(negedge CLK) begin
        if (mon_en) begin
            chk("busy", 32'(bus.busy), 32'(q_exp.size() != 0));
            if (q_exp.size() == 0) begin
                chk("idle_valid", 32'(bus.addr_valid), 0);
                chk("idle_done", 32'(bus.done), 0);
            end else if (q_exp[0].is_done) begin
                chk("done_pulse", 32'(bus.done), 1);
                chk("done_valid", 32'(bus.addr_valid), 0);
                void'(q_exp.pop_front());
            end else begin
                chk("send_valid", 32'(bus.addr_valid), 1);
                chk("send_done", 32'(bus.done), 0);
                if (prev_stall) chk("stall_hold", 32'(bus.source_address), 32'(prev_addr));
                if (bus.addr_valid && bus.addr_ready) begin
                    chk("address", 32'(bus.source_address), 32'(q_exp[0].addr));
                    void'(q_exp.pop_front());
                end
            end
            prev_stall = bus.addr_valid && !bus.addr_ready;
            prev_addr  = bus.source_address;
        end
    end

    // One timestep, entered and left at posedge+1.
    // rmode: 0 ready=1, 1 random, 2 stall 3 cycles, 3 stall 300 cycles.
    // jmode: 0 no extra strobes, 1 random, 2 every cycle, 3 first cycle only.
    task automatic run_timestep(input logic [11:0] base, input logic [9:0] vec,
                                input int rmode, input int jmode);
        int cycles;
        bus.base_address = base;
        bus.fire_vec     = vec;
        bus.fire_valid   = 1'b1;
        @(posedge CLK);
        push_expect(base, vec);
        #1;
        bus.fire_valid   = 1'b0;
        bus.base_address = 12'($urandom);
        bus.fire_vec     = 10'($urandom);
        cycles = 0;
        while (!bus.done && cycles < 1000) begin
            case (rmode)
                0:       bus.addr_ready = 1'b1;
                2:       bus.addr_ready = (cycles >= 3);
                3:       bus.addr_ready = (cycles >= 300);
                default: bus.addr_ready = ($urandom_range(0, 3) != 0);
            endcase
            if ((jmode == 1 && $urandom_range(0, 3) == 0) || jmode == 2 ||
                (jmode == 3 && cycles == 0)) begin
                bus.fire_valid = 1'b1;
                bus.fire_vec   = 10'($urandom);
                note_reject();
            end else begin
                bus.fire_valid = 1'b0;
            end
            @(posedge CLK);
            #1;
            cycles++;
        end
        if (cycles >= 1000) begin
            n_cmp++;
            n_err++;
            $display("FAIL timeout: no done after %0d cycles", cycles);
        end
        // The cycle that shows done is still not IDLE: a strobe here is dropped.
        if (jmode != 0) begin
            bus.fire_valid = 1'b1;
            note_reject();
        end else begin
            bus.fire_valid = 1'b0;
        end
        @(posedge CLK);
        #1;
        bus.fire_valid = 1'b0;
        chk("ovf_count", 32'(bus.ovf_count), 32'(exp_ovf()));
    endtask

    initial begin
        logic [11:0] b;
        logic [9:0]  v;
        bus.base_address = '0;
        bus.fire_vec     = '0;
        bus.fire_valid   = 1'b0;
        bus.addr_ready   = 1'b0;
        RST = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_addr", 32'(bus.source_address), 0);
        chk("rst_valid", 32'(bus.addr_valid), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_ovf", 32'(bus.ovf_count), 0);
        RST = 1'b0;
        mon_en = 1;
        @(posedge CLK);
        #1;

        run_timestep(12'd8, 10'b0000010011, 0, 0);      // 8, 9, 12
        run_timestep(12'd8, 10'b0000000100, 2, 0);      // 10 held through stall
        run_timestep(12'd8, 10'b0000000000, 0, 0);      // empty timestep
        run_timestep(12'd5, 10'b0000000111, 1, 3);      // one drop mid-SEND
        run_timestep(12'hFFE, 10'b0000001010, 0, 0);    // FFF, 001
        run_timestep(12'd100, 10'b1111111111, 3, 2);    // >300 drops, saturates

        // Reset after the first handshake of a four-address timestep.
        bus.base_address = 12'd20;
        bus.fire_vec     = 10'b0000001111;
        bus.fire_valid   = 1'b1;
        bus.addr_ready   = 1'b1;
        @(posedge CLK);
        push_expect(12'd20, 10'b0000001111);
        #1;
        bus.fire_valid = 1'b0;
        @(posedge CLK);
        #1;
        RST = 1'b1;
        @(posedge CLK);
        q_exp.delete();
        model_ovf = 0;
        #1;
        chk("rst_mid_valid", 32'(bus.addr_valid), 0);
        chk("rst_mid_busy", 32'(bus.busy), 0);
        chk("rst_mid_done", 32'(bus.done), 0);
        chk("rst_mid_ovf", 32'(bus.ovf_count), 0);
        RST = 1'b0;
        repeat (2) begin
            @(posedge CLK);
            #1;
        end
        run_timestep(12'd40, 10'b1000000001, 0, 0);

        for (int t = 0; t < 30; t++) begin
            b = 12'($urandom);
            if ($urandom_range(0, 3) == 0) b = 12'hFF8 + 12'($urandom_range(0, 7));
            case ($urandom_range(0, 5))
                0:       v = 10'h000;
                1:       v = 10'h3FF;
                default: v = 10'($urandom);
            endcase
            repeat ($urandom_range(0, 2)) begin
                @(posedge CLK);
                #1;
            end
            run_timestep(b, v, 1, 1);
        end

        repeat (3) begin
            @(posedge CLK);
            #1;
        end
        chk("queue_drained", 32'(q_exp.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Global time limit.
    initial begin
        #2000000;
        n_cmp++;
        n_err++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_spike_address_tx
`default_nettype wire
